// File: rtl/lvt_port_scheduler_if.sv
// Purpose : bundles requester, response, clear-control and memory-port signals of lvt_port_scheduler.
// Latency : none; wires only.
// Backpress: req_valid/req_ready handshake per requester; rsp_valid has no backpressure.
// Modports : slave  = scheduler side (drives req_ready, rsp_*, clr_done, busy, wr*/rd0 controls)
//            master = requester/memory side (drives req_*, clr_req, rd0_data)
interface lvt_port_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;

    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;

    logic                    clr_req;
    logic                    clr_done;
    logic                    busy;

    logic                    wr0_en;
    logic [ADDR_W-1:0]       wr0_addr;
    logic [DATA_W-1:0]       wr0_data;
    logic                    wr1_en;
    logic [ADDR_W-1:0]       wr1_addr;
    logic [DATA_W-1:0]       wr1_data;
    logic                    rd0_en;
    logic [ADDR_W-1:0]       rd0_addr;
    logic [DATA_W-1:0]       rd0_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, clr_req, rd0_data,
        output req_ready, rsp_valid, rsp_id, rsp_data, clr_done, busy,
               wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               rd0_en, rd0_addr
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, clr_req, rd0_data,
        input  req_ready, rsp_valid, rsp_id, rsp_data, clr_done, busy,
               wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               rd0_en, rd0_addr
    );
endinterface

// File: rtl/lvt_port_scheduler.sv
// Purpose : round-robin scheduler sharing a 2W/1R live-value-table among N_REQ requesters, with clear sweep.
// Latency : grants and memory controls are combinational; read response one cycle after grant.
// Backpress: ungranted requesters see req_ready=0 and hold; all readies 0 while clearing.
// Ports    : clk, rst (async active-high); bus = lvt_port_scheduler_if.slave carrying requests,
//            read responses, clr_req/clr_done/busy and the wr0/wr1/rd0 memory port controls.
// Option   : define LVT_SCHED_RAW_FWD_EN to grant same-address reads alongside a write and
//            forward the write data into the response instead of stalling the read.
module lvt_port_scheduler #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    lvt_port_scheduler_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'((2 ** ADDR_W) - 2);

    typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_DONE} state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_busy;
    logic              r_clr_done;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
`ifdef LVT_SCHED_RAW_FWD_EN
    logic              r_fwd_vld;
    logic [DATA_W-1:0] r_fwd_data;
`endif

    logic              w_run;
    logic [PTR_W-1:0]  w_scan  [N_REQ];
    logic [ADDR_W-1:0] w_addr  [N_REQ];
    logic [DATA_W-1:0] w_wdata [N_REQ];

    // Holding reset forces every combinational output to its idle value too.
    assign w_run = (r_state == ST_RUN) && !rst;

    // Scan order: requester index visited at step g is (rr_ptr + g) mod N_REQ.
    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        logic [PTR_W:0] w_sum;
        assign w_sum      = {1'b0, r_rr_ptr} + (PTR_W+1)'(g);
        assign w_scan[g]  = (w_sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(w_sum - (PTR_W+1)'(N_REQ))
                                                           : w_sum[PTR_W-1:0];
        assign w_addr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    logic             w_w0_vld, w_w1_vld, w_w1_seen, w_rd_cand, w_rd_vld;
    logic [PTR_W-1:0] w_w0_idx, w_w1_idx, w_rd_idx;
    logic [PTR_W-1:0] w_w0_k, w_w1_k, w_rd_k, w_last_k;
    logic             w_rd_hit0, w_rd_hit1;
    logic [PTR_W:0]   w_next_sum;
    logic [PTR_W-1:0] w_next_ptr;
    logic [N_REQ-1:0] w_ready;

    always_comb begin
        w_w0_vld  = 1'b0;
        w_w0_idx  = '0;
        w_w0_k    = '0;
        w_w1_vld  = 1'b0;
        w_w1_idx  = '0;
        w_w1_k    = '0;
        w_w1_seen = 1'b0;
        w_rd_cand = 1'b0;
        w_rd_idx  = '0;
        w_rd_k    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_run && bus.req_valid[w_scan[k]]) begin
                if (bus.req_we[w_scan[k]]) begin
                    if (!w_w0_vld) begin
                        w_w0_vld = 1'b1;
                        w_w0_idx = w_scan[k];
                        w_w0_k   = PTR_W'(k);
                    end else if (!w_w1_seen) begin
                        // Only the second write in scan order may take port 1; if it
                        // collides with port 0 it waits, so same-address writes keep order.
                        w_w1_seen = 1'b1;
                        if (w_addr[w_scan[k]] != w_addr[w_w0_idx]) begin
                            w_w1_vld = 1'b1;
                            w_w1_idx = w_scan[k];
                            w_w1_k   = PTR_W'(k);
                        end
                    end
                end else if (!w_rd_cand) begin
                    w_rd_cand = 1'b1;
                    w_rd_idx  = w_scan[k];
                    w_rd_k    = PTR_W'(k);
                end
            end
        end

        w_rd_hit0 = w_w0_vld && (w_addr[w_rd_idx] == w_addr[w_w0_idx]);
        w_rd_hit1 = w_w1_vld && (w_addr[w_rd_idx] == w_addr[w_w1_idx]);
`ifdef LVT_SCHED_RAW_FWD_EN
        w_rd_vld  = w_rd_cand;
`else
        // The memory reads the old value during a same-cycle write, so stall the read.
        w_rd_vld  = w_rd_cand && !w_rd_hit0 && !w_rd_hit1;
`endif

        w_last_k = '0;
        if (w_w0_vld) w_last_k = w_w0_k;
        if (w_w1_vld && (w_w1_k > w_last_k)) w_last_k = w_w1_k;
        if (w_rd_vld && (w_rd_k > w_last_k)) w_last_k = w_rd_k;
        w_next_sum = {1'b0, r_rr_ptr} + {1'b0, w_last_k} + (PTR_W+1)'(1);
        w_next_ptr = (w_next_sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(w_next_sum - (PTR_W+1)'(N_REQ))
                                                        : w_next_sum[PTR_W-1:0];

        w_ready = '0;
        if (w_w0_vld) w_ready[w_w0_idx] = 1'b1;
        if (w_w1_vld) w_ready[w_w1_idx] = 1'b1;
        if (w_rd_vld) w_ready[w_rd_idx] = 1'b1;
    end

    logic              w_wr0_en, w_wr1_en, w_rd0_en;
    logic [ADDR_W-1:0] w_wr0_addr, w_wr1_addr, w_rd0_addr;
    logic [DATA_W-1:0] w_wr0_data, w_wr1_data;

    always_comb begin
        w_wr0_en   = w_w0_vld;
        w_wr0_addr = w_w0_vld ? w_addr[w_w0_idx]  : '0;
        w_wr0_data = w_w0_vld ? w_wdata[w_w0_idx] : '0;
        w_wr1_en   = w_w1_vld;
        w_wr1_addr = w_w1_vld ? w_addr[w_w1_idx]  : '0;
        w_wr1_data = w_w1_vld ? w_wdata[w_w1_idx] : '0;
        w_rd0_en   = w_rd_vld;
        w_rd0_addr = w_rd_vld ? w_addr[w_rd_idx]  : '0;
        if ((r_state == ST_CLEAR) && !rst) begin
            w_wr0_en   = 1'b1;
            w_wr0_addr = r_clr_cnt;
            w_wr0_data = '0;
            w_wr1_en   = 1'b1;
            w_wr1_addr = r_clr_cnt + ADDR_W'(1);
            w_wr1_data = '0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr0_en    = w_wr0_en;
    assign bus.wr0_addr  = w_wr0_addr;
    assign bus.wr0_data  = w_wr0_data;
    assign bus.wr1_en    = w_wr1_en;
    assign bus.wr1_addr  = w_wr1_addr;
    assign bus.wr1_data  = w_wr1_data;
    assign bus.rd0_en    = w_rd0_en;
    assign bus.rd0_addr  = w_rd0_addr;
    assign bus.busy      = r_busy;
    assign bus.clr_done  = r_clr_done;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
`ifdef LVT_SCHED_RAW_FWD_EN
    assign bus.rsp_data  = !r_rsp_valid ? '0 : (r_fwd_vld ? r_fwd_data : bus.rd0_data);
`else
    assign bus.rsp_data  = r_rsp_valid ? bus.rd0_data : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_rr_ptr    <= '0;
            r_clr_cnt   <= '0;
            r_busy      <= 1'b0;
            r_clr_done  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
`ifdef LVT_SCHED_RAW_FWD_EN
            r_fwd_vld   <= 1'b0;
            r_fwd_data  <= '0;
`endif
        end else begin
            // Responses are independent of the FSM so a read granted in the last
            // RUN cycle still completes while the sweep begins.
            r_rsp_valid <= w_rd_vld;
            if (w_rd_vld) r_rsp_id <= ID_W'(w_rd_idx);
`ifdef LVT_SCHED_RAW_FWD_EN
            r_fwd_vld <= w_rd_vld && (w_rd_hit0 || w_rd_hit1);
            if (w_rd_vld) r_fwd_data <= w_rd_hit0 ? w_wdata[w_w0_idx] : w_wdata[w_w1_idx];
`endif
            if (w_w0_vld || w_w1_vld || w_rd_vld) r_rr_ptr <= w_next_ptr;

            case (r_state)
                ST_RUN: begin
                    if (bus.clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_W'(2);
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state    <= ST_DONE;
                        r_clr_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_RUN;
                    r_busy     <= 1'b0;
                    r_clr_done <= 1'b0;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_busy     <= 1'b0;
                    r_clr_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lvt_port_scheduler.sv
// Purpose : scoreboard bench for lvt_port_scheduler with a behavioural 2W/1R registered-read memory.
// Latency : responses expected one cycle after the read grant.
// Backpress: requesters hold valid until they see ready.
module tb_lvt_port_scheduler;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lvt_port_scheduler_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
    lvt_port_scheduler #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: writes land on the edge ending the grant cycle; reads return old data next cycle.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always @(posedge clk) begin
        if (bus.rd0_en) bus.rd0_data <= mem[bus.rd0_addr];
        if (bus.wr0_en) mem[bus.wr0_addr] <= bus.wr0_data;
        if (bus.wr1_en) mem[bus.wr1_addr] <= bus.wr1_data;
    end

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.clr_done) done_cnt++;
        if (!rst && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_unexpected: got id=%0d data=0x%0h expected no response",
                         bus.rsp_id, bus.rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
                check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int id, input logic [DATA_W-1:0] d);
        exp_q.push_back('{id: ID_W'(id), data: d});
    endtask

    task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_we[i]    = we;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single transfer; holds the request until granted, bounded to 20 cycles.
    task automatic xfer(input int i, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input string name);
        bit got;
        got = 1'b0;
        set_req(i, we, a, d);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.req_ready[i]) got = 1'b1;
            step();
        end
        bus.req_valid[i] = 1'b0;
        check(name, 64'(got), 64'd1);
    endtask

    logic [N_REQ-1:0]  exp_rdy;
    logic [DATA_W-1:0] fair_data [N_REQ];
    int bad, busy_cnt, done0;

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.clr_req   = 1'b0;
        set_req(0, 1'b0, 7'd1, '0);
        repeat (3) step();

        // Reset state, with a request pending
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_clr_done",  64'(bus.clr_done),  64'd0);
        check("rst_mem_en",    64'({bus.wr0_en, bus.wr1_en, bus.rd0_en}), 64'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        step();

        // Single read after write (rr_ptr: 0 -> 1 -> 2)
        xfer(0, 1'b1, 7'd5, 32'hA5A5_0001, "wr5_grant");
        push_exp(1, 32'hA5A5_0001);
        xfer(1, 1'b0, 7'd5, '0, "rd5_grant");

        // Write conflict at address 9; req3 grant first to bring rr_ptr back to 0
        xfer(3, 1'b1, 7'd20, 32'h0000_2020, "wr20_grant");
        set_req(0, 1'b1, 7'd9, 32'h0009_0000);
        set_req(2, 1'b1, 7'd9, 32'h0009_0002);
        @(negedge clk);
        check("conflict_c1_ready", 64'(bus.req_ready), 64'b0001);
        check("conflict_c1_wr1_en", 64'(bus.wr1_en), 64'd0);
        step();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("conflict_c2_ready", 64'(bus.req_ready), 64'b0100);
        step();
        bus.req_valid[2] = 1'b0;
        push_exp(1, 32'h0009_0002);
        xfer(1, 1'b0, 7'd9, '0, "rd9_grant");

        // Fairness: rr_ptr to 0 via a req3 read, then all four read continuously
        push_exp(3, 32'h0000_2020);
        xfer(3, 1'b0, 7'd20, '0, "rd20_grant");
        fair_data[0] = 32'hA5A5_0001;
        fair_data[1] = 32'h0009_0002;
        fair_data[2] = 32'h0000_2020;
        fair_data[3] = 32'hA5A5_0001;
        set_req(0, 1'b0, 7'd5,  '0);
        set_req(1, 1'b0, 7'd9,  '0);
        set_req(2, 1'b0, 7'd20, '0);
        set_req(3, 1'b0, 7'd5,  '0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_rdy = '0;
            exp_rdy[c % N_REQ] = 1'b1;
            check("fair_ready", 64'(bus.req_ready), 64'(exp_rdy));
            push_exp(c % N_REQ, fair_data[c % N_REQ]);
            step();
        end
        bus.req_valid = '0;

        // Read-after-write on address 3 (rr_ptr = 0)
        push_exp(1, 32'h0000_1234);
        set_req(0, 1'b1, 7'd3, 32'h0000_1234);
        set_req(1, 1'b0, 7'd3, '0);
        @(negedge clk);
`ifdef LVT_SCHED_RAW_FWD_EN
        check("raw_c1_ready", 64'(bus.req_ready), 64'b0011);
        step();
        bus.req_valid = '0;
`else
        check("raw_c1_ready", 64'(bus.req_ready), 64'b0001);
        step();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("raw_c2_ready", 64'(bus.req_ready), 64'b0010);
        step();
        bus.req_valid[1] = 1'b0;
`endif
        step();

        // Fill all 128 addresses with addr + 0x100, two per cycle
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            set_req(0, 1'b1, ADDR_W'(2*k),   32'(2*k + 256));
            set_req(1, 1'b1, ADDR_W'(2*k+1), 32'(2*k + 257));
            @(negedge clk);
            if (bus.req_ready !== 4'b0011) bad++;
            step();
        end
        bus.req_valid = '0;
        check("fill_dual_grants", 64'(bad), 64'd0);

        // Clear sweep, with a read of 127 granted in the same cycle as clr_req
        push_exp(1, 32'h0000_017F);
        set_req(1, 1'b0, 7'd127, '0);
        bus.clr_req = 1'b1;
        @(negedge clk);
        check("pre_clear_rd_ready", 64'(bus.req_ready), 64'b0010);
        step();
        bus.clr_req = 1'b0;
        bus.req_valid[1] = 1'b0;
        push_exp(2, 32'h0);
        set_req(2, 1'b0, 7'd64, '0);
        done0 = done_cnt;
        bad = 0;
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.req_ready !== '0 || bus.rd0_en !== 1'b0) bad++;
            step();
        end
        check("post_clear_ready", 64'(bus.req_ready), 64'b0100);
        step();
        bus.req_valid[2] = 1'b0;
        check("clear_busy_cycles", 64'(busy_cnt), 64'd65);
        check("clear_ready_low", 64'(bad), 64'd0);
        check("clear_done_pulses", 64'(done_cnt - done0), 64'd1);
        push_exp(0, 32'h0);
        xfer(0, 1'b0, 7'd0, '0, "rd0_after_clear");
        push_exp(3, 32'h0);
        xfer(3, 1'b0, 7'd127, '0, "rd127_after_clear");

        // Reset ten cycles into a sweep
        xfer(0, 1'b1, 7'd100, 32'hBEEF_0064, "wr100_grant");
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        repeat (10) step();
        check("midclr_busy_before_rst", 64'(bus.busy), 64'd1);
        done0 = done_cnt;
        rst = 1'b1;
        #1;
        check("midclr_rst_busy",  64'(bus.busy), 64'd0);
        check("midclr_rst_done",  64'(bus.clr_done), 64'd0);
        check("midclr_rst_mem_en", 64'({bus.wr0_en, bus.wr1_en, bus.rd0_en}), 64'd0);
        check("midclr_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (80) step();
        check("midclr_no_done", 64'(done_cnt - done0), 64'd0);
        check("midclr_busy_after", 64'(bus.busy), 64'd0);
        push_exp(2, 32'hBEEF_0064);
        xfer(2, 1'b0, 7'd100, '0, "rd100_after_abort");
        push_exp(1, 32'h0);
        xfer(1, 1'b0, 7'd10, '0, "rd10_after_abort");

        repeat (3) step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
